// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU
// Optional macro ITERATIVE_DIVIDER_EARLY_EXIT_EN: divide-by-zero and signed overflow
// finish in one cycle instead of running the full CALC sequence.
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] spec_q;
  logic [WIDTH-1:0] spec_r;
  logic             neg_q;
  logic             neg_r;
  logic             special;

  logic             accept;
  logic             a_neg;
  logic             b_neg;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  // Operand conditioning, special-case detection and one restoring step.
  always_comb begin
    a_neg    = signed_op & dividend[WIDTH-1];
    b_neg    = signed_op & divisor[WIDTH-1];
    a_mag    = a_neg ? -dividend : dividend;
    b_mag    = b_neg ? -divisor : divisor;
    div_zero = (divisor == '0);
    overflow = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    shifted  = (prem << 1) | {{WIDTH{1'b0}}, dq[WIDTH-1]};
    trial    = shifted - {1'b0, dvs_mag};
    rem_mag  = prem[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, accept strobe and busy.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
`ifdef ITERATIVE_DIVIDER_EARLY_EXIT_EN
          state_next = (div_zero || overflow) ? FIX : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
`ifdef ITERATIVE_DIVIDER_EARLY_EXIT_EN
        busy = ~special;
`else
        busy = 1'b1;
`endif
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift/subtract iterations and sign fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      prem      <= '0;
      dq        <= '0;
      dvs_mag   <= '0;
      spec_q    <= '0;
      spec_r    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special   <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dq      <= a_mag;
            dvs_mag <= b_mag;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            special <= div_zero | overflow;
            spec_q  <= div_zero ? '1 : dividend;
            spec_r  <= div_zero ? dividend : '0;
            prem    <= '0;
            count   <= CW'(WIDTH);
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (!trial[WIDTH]) begin
            prem <= trial;
            dq   <= {dq[WIDTH-2:0], 1'b1};
          end else begin
            prem <= shifted;
            dq   <= {dq[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          done <= 1'b1;
          if (special) begin
            quotient  <= spec_q;
            remainder <= spec_r;
          end else begin
            quotient  <= neg_q ? -dq : dq;
            remainder <= neg_r ? -rem_mag : rem_mag;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/iterative_divider.md
Name: iterative_divider

Overview:
- Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU path; the subtract-side counterpart of the combinational ripple-carry adder datapath.
- Produces quotient and remainder with a start/done handshake.
- Sits beside the ALU in the execute stage; the core stalls while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- signed_op  input  1  1 = two's-complement DIV/REM semantics, 0 = unsigned
- dividend  input  WIDTH  numerator, sampled with start
- divisor  input  WIDTH  denominator, sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, internal registers=0. An in-flight operation is discarded, and no done is produced for it.
- States: IDLE, CALC, FIX.
- IDLE:
  - On an edge with start=1, latch the operands and signed_op.
  - Latch magnitudes: when signed_op=1 and an operand is negative, store its two's-complement negation.
  - Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend); both are 0 when unsigned.
  - Load count=WIDTH and clear the partial remainder (WIDTH+1 bits). Go to CALC; busy=1 from the next cycle.
- CALC, one quotient bit per edge:
  - Shift {partial remainder, dividend magnitude} left by 1.
  - trial = partial remainder - divisor magnitude, computed at WIDTH+1 bits.
  - If trial >= 0, keep trial and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement count. After the WIDTH-th CALC edge, go to FIX.
- FIX, one edge:
  - quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (WIDTH-bit wrap).
  - done=1 for exactly this cycle, busy=0; go to IDLE.
- Latency: with start sampled at edge 0, done is high after edge WIDTH+1 (33 edges for WIDTH=32). busy is high after edges 1..WIDTH.
- Special cases follow RISC-V exactly and are detected at the IDLE edge:
  - divisor==0: quotient = all ones, remainder = dividend, for both signed and unsigned.
  - signed_op=1, dividend = -2^(WIDTH-1), divisor = -1: quotient = dividend, remainder = 0.
- start while busy=1 is ignored. start in the done cycle (busy=0) is accepted: back-to-back operation, no dead cycle.
- quotient and remainder hold their value from done until the next done. They do not change during CALC.
- Operand inputs are don't-care except on the accepting edge.

Optional Feature:
- Macro: ITERATIVE_DIVIDER_EARLY_EXIT_EN.
- Defined: both special cases skip CALC. The IDLE edge loads the special results into the FIX path, so done is high after edge 1 (latency 1), with busy=0 throughout.
- Undefined: the special cases still run the full CALC/FIX sequence with the normal latency WIDTH+1. The FIX edge substitutes the RISC-V special values. Latency is constant for every input.

Test Plan:
- Unsigned 100/7, WIDTH=32 -> quotient=14, remainder=2; done high exactly after edge 33; single-cycle pulse; busy high during edges 1..32.
- Signed -7/2 (0xFFFFFFF9 / 0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. The same bits unsigned -> quotient=0x7FFFFFFC, remainder=0x1.
- Divide by zero, 5/0 (signed and unsigned) -> quotient=0xFFFFFFFF, remainder=5. Done after edge 1 with EARLY_EXIT_EN defined, after edge 33 without.
- Signed overflow 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0. Latency as in the divide-by-zero case.
- Pulse start again at cycle 10 with other operands while busy -> ignored; the first result is unchanged. A new start in the done cycle -> accepted, second done exactly 33 edges later.
- Assert rst mid-CALC (cycle 15) -> busy, done, quotient and remainder go to 0 immediately (asynchronously). No done follows. A fresh start after reset release completes correctly.
